// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to a
// 1-cycle instruction memory and buffers {pc, instr} pairs.
module fetch_queue #(
  parameter int XLEN       = 32,
  parameter int IMEM_BYTES = 128,
  parameter int QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        imem_req,
  output logic [XLEN-1:0]             imem_addr,
  input  logic [XLEN-1:0]             imem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_instr,
  output logic [XLEN-1:0]             out_pc,
  output logic [$clog2(QDEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [XLEN-1:0] AMASK =
    XLEN'(IMEM_BYTES - 1) & ~XLEN'(3);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] mem_pc    [QDEPTH];
  logic [XLEN-1:0] mem_instr [QDEPTH];
  logic            pop;
  logic            push;
  logic [CW:0]     occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // Occupancy the queue will have once the in-flight word lands.
  assign occ       = {1'b0, count} + (CW+1)'(inflight)
                   - (CW+1)'(pop);
  assign imem_req  = !reset && !redirect_valid
                   && (occ < (CW+1)'(QDEPTH));
  assign imem_addr = pc & AMASK;
  // A response only lands if its request survived; reset and
  // redirect clear inflight, which squashes any stale word.
  assign push      = inflight && !reset && !redirect_valid;
  assign out_instr = mem_instr[rd_ptr];
  assign out_pc    = mem_pc[rd_ptr];
  assign q_count   = count;

  // Fetch PC, in-flight tracking, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & AMASK;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        req_pc <= imem_addr;
        pc     <= (pc + XLEN'(4)) & AMASK;
      end
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= req_pc;
      mem_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule
